// File: rtl/pwm_multi_ch.sv
// N-channel PWM peripheral with per-channel prescaler, edge/centre-aligned counter,
// shadowed DIV/PERIOD/DUTY and sticky period-end flags driving a level IRQ.
module pwm_multi_ch #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [NUM_CH-1:0] oe_pwm_o,
  output logic              irq_o
);

  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'('h80);
  localparam logic [ADDR_W-1:0] IRQ_EN_ADDR = ADDR_W'('h84);
  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_DIV    = 2'd1;
  localparam logic [1:0] OFS_PERIOD = 2'd2;
  localparam logic [1:0] OFS_DUTY   = 2'd3;

  logic [31:0]       ch_idx;
  logic [1:0]        reg_ofs;
  logic              ch_hit;
  logic              wr_status;
  logic              wr_irq_en;
  logic [NUM_CH-1:0] bnd;
  logic [NUM_CH-1:0] status_q;
  logic [NUM_CH-1:0] irq_en_q;
  logic [NUM_CH-1:0] w1c;
  logic [DATA_W-1:0] rd_regs [NUM_CH][4];

  // Channel window is 0x00..0x7F, one 16-byte block per existing channel.
  assign ch_idx    = 32'(addr_i[6:4]);
  assign reg_ofs   = addr_i[3:2];
  assign ch_hit    = (addr_i[ADDR_W-1:7] == '0) && (addr_i[1:0] == 2'b00) &&
                     (ch_idx < 32'(NUM_CH));
  assign wr_status = write && (addr_i == STATUS_ADDR);
  assign wr_irq_en = write && (addr_i == IRQ_EN_ADDR);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [3:0]       ctrl_q;
    logic [CNT_W-1:0] div_p, per_p, duty_p;
    logic [CNT_W-1:0] div_a, per_a, duty_a;
    logic [CNT_W-1:0] div_n, per_n, duty_n;
    logic [CNT_W-1:0] pre_q, cnt_q, cnt_d;
    logic             down_q, down_d, pwm_q;
    logic             sel, wr_ctrl, wr_div, wr_per, wr_duty;
    logic             en, pol, centre, tick, bnd_c;

    assign en      = ctrl_q[0];
    assign pol     = ctrl_q[2];
    assign centre  = ctrl_q[3];
    assign sel     = write && ch_hit && (ch_idx == 32'(g));
    assign wr_ctrl = sel && (reg_ofs == OFS_CTRL);
    assign wr_div  = sel && (reg_ofs == OFS_DIV);
    assign wr_per  = sel && (reg_ofs == OFS_PERIOD);
    assign wr_duty = sel && (reg_ofs == OFS_DUTY);

    // A write landing on the boundary edge is loaded into the active copy at that edge.
    assign div_n  = wr_div  ? wdata_i[CNT_W-1:0] : div_p;
    assign per_n  = wr_per  ? wdata_i[CNT_W-1:0] : per_p;
    assign duty_n = wr_duty ? wdata_i[CNT_W-1:0] : duty_p;

    always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      cnt_d  = cnt_q;
      down_d = down_q;
      bnd_c  = 1'b0;
      tick   = en && (pre_q == div_a);
      if (tick) begin
        if (!centre) begin
          down_d = 1'b0;
          if (cnt_q >= per_a) begin
            cnt_d = '0;
            bnd_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!down_q) begin
          if (cnt_q >= per_a) begin
            // PERIOD 0/1 have no down slope; the top itself closes the period.
            if (per_a <= CNT_W'(1)) begin
              cnt_d = '0;
              bnd_c = 1'b1;
            end else begin
              cnt_d  = per_a - CNT_W'(1);
              down_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (cnt_q <= CNT_W'(1)) begin
          cnt_d  = '0;
          down_d = 1'b0;
          bnd_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        ctrl_q <= '0;
        div_p  <= '0;
        per_p  <= '0;
        duty_p <= '0;
        div_a  <= '0;
        per_a  <= '0;
        duty_a <= '0;
        pre_q  <= '0;
        cnt_q  <= '0;
        down_q <= 1'b0;
        pwm_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (wr_ctrl) ctrl_q <= wdata_i[3:0];
        if (wr_div)  div_p  <= wdata_i[CNT_W-1:0];
        if (wr_per)  per_p  <= wdata_i[CNT_W-1:0];
        if (wr_duty) duty_p <= wdata_i[CNT_W-1:0];
        if (!en || bnd_c) begin
          div_a  <= div_n;
          per_a  <= per_n;
          duty_a <= duty_n;
        end
        if (!en) begin
          pre_q  <= '0;
          cnt_q  <= '0;
          down_q <= 1'b0;
        end else begin
          pre_q  <= tick ? '0 : pre_q + CNT_W'(1);
          cnt_q  <= cnt_d;
          down_q <= down_d;
        end
        if (wr_ctrl && (wdata_i[3] != centre)) down_q <= 1'b0;
        pwm_q <= en ? ((cnt_q < duty_a) ^ pol) : pol;
      end
    end

    assign bnd[g]         = bnd_c;
    assign pwm_o[g]       = pwm_q;
    assign oe_pwm_o[g]    = ctrl_q[1];
    assign rd_regs[g][0]  = DATA_W'(ctrl_q);
    assign rd_regs[g][1]  = DATA_W'(div_p);
    assign rd_regs[g][2]  = DATA_W'(per_p);
    assign rd_regs[g][3]  = DATA_W'(duty_p);
  end

  // Set wins over a same-cycle write-one-to-clear.
  assign w1c = wr_status ? wdata_i[NUM_CH-1:0] : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
      irq_en_q <= '0;
    end else begin
      status_q <= (status_q & ~w1c) | bnd;
      if (wr_irq_en) irq_en_q <= wdata_i[NUM_CH-1:0];
    end
  end

  assign irq_o = |(status_q & irq_en_q);

  always_comb begin
    rdata_o = '0;
    if (addr_i == STATUS_ADDR) begin
      rdata_o = DATA_W'(status_q);
    end else if (addr_i == IRQ_EN_ADDR) begin
      rdata_o = DATA_W'(irq_en_q);
    end else if (ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_idx == 32'(c)) rdata_o = rd_regs[c][reg_ofs];
      end
    end
  end

endmodule
